// File: rtl/watch_pkg.sv
// Shared watch types: time-set FSM states and two-digit BCD increment helpers.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10,
    COMMIT = 2'b11
  } state_t;

  // Hours wrap 23 -> 00; units roll into tens otherwise.
  function automatic logic [7:0] bcd_inc_hour(input logic [3:0] dez, input logic [3:0] uni);
    if (dez == 4'd2 && uni == 4'd3) return 8'h00;
    else if (uni == 4'd9)           return {dez + 4'd1, 4'd0};
    else                            return {dez, uni + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [3:0] dez, input logic [3:0] uni);
    if (uni == 4'd9) begin
      if (dez == 4'd5) return 8'h00;
      else             return {dez + 4'd1, 4'd0};
    end
    else return {dez, uni + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_autorepeat.sv
// Rising-edge detector with hold-to-repeat: a step on the press, then after
// REPEAT_DELAY held cycles one step every REPEAT_RATE cycles until release.
module btn_autorepeat #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise,
  output logic step
);

  localparam int CW = $clog2(REPEAT_DELAY + 1);

  logic          prev;
  logic [CW-1:0] hold;

  assign rise = btn & ~prev;
  assign step = rise | (btn & prev & (hold == CW'(REPEAT_DELAY)));

  // hold counts cycles since the press; after each repeat it is pulled back
  // so the next match lands REPEAT_RATE cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
      hold <= '0;
    end else begin
      prev <= btn;
      if (!btn)                             hold <= '0;
      else if (rise)                        hold <= CW'(1);
      else if (hold == CW'(REPEAT_DELAY))   hold <= CW'(REPEAT_DELAY - REPEAT_RATE + 1);
      else                                  hold <= hold + CW'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Watch time-setting controller: hour then minute editing with blink mask,
// inactivity timeout and a one-cycle load of HH:MM:00 into the clock counter.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int BLINK_HALF   = 250,
  parameter int TIMEOUT      = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic [3:0] cur_h_dez,
  input  logic [3:0] cur_h_uni,
  input  logic [3:0] cur_m_dez,
  input  logic [3:0] cur_m_uni,
  output logic       edit_active,
  output logic       blank_h,
  output logic       blank_m,
  output logic [3:0] edt_h_dez,
  output logic [3:0] edt_h_uni,
  output logic [3:0] edt_m_dez,
  output logic [3:0] edt_m_uni,
  output logic       load
);

  localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  state_t        state, next_state;
  logic          prev_set, prev_cancel;
  logic          set_rise, cancel_rise, inc_rise, inc_step;
  logic          any_edge, timed_out, edit_state, entering;
  logic          snapshot, inc_hour, inc_min;
  logic [TW-1:0] tout_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  assign set_rise    = btn_set & ~prev_set;
  assign cancel_rise = btn_cancel & ~prev_cancel;

  btn_autorepeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .rise  (inc_rise),
    .step  (inc_step)
  );

  assign any_edge   = set_rise | inc_rise | cancel_rise;
  assign timed_out  = ~any_edge & (tout_cnt == TW'(TIMEOUT - 1));
  assign edit_state = (state == EDIT_H) | (state == EDIT_M);

  // Per-cycle priority: abort (cancel/en/timeout) > set > inc step.
  always_comb begin
    next_state = state;
    snapshot   = 1'b0;
    inc_hour   = 1'b0;
    inc_min    = 1'b0;
    case (state)
      IDLE: begin
        if (set_rise & en & ~cancel_rise) begin
          next_state = EDIT_H;
          snapshot   = 1'b1;
        end
      end
      EDIT_H: begin
        if (cancel_rise | ~en | timed_out) next_state = IDLE;
        else if (set_rise)                 next_state = EDIT_M;
        else if (inc_step)                 inc_hour   = 1'b1;
      end
      EDIT_M: begin
        if (cancel_rise | ~en | timed_out) next_state = IDLE;
        else if (set_rise)                 next_state = COMMIT;
        else if (inc_step)                 inc_min    = 1'b1;
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign entering = (next_state != state) & ((next_state == EDIT_H) | (next_state == EDIT_M));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev_set    <= 1'b0;
      prev_cancel <= 1'b0;
    end else begin
      state       <= next_state;
      prev_set    <= btn_set;
      prev_cancel <= btn_cancel;
    end
  end

  // The buffer keeps its contents on abort; only reset or a new entry replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {edt_h_dez, edt_h_uni, edt_m_dez, edt_m_uni} <= 16'h0000;
    end else if (snapshot) begin
      {edt_h_dez, edt_h_uni, edt_m_dez, edt_m_uni} <= {cur_h_dez, cur_h_uni, cur_m_dez, cur_m_uni};
    end else if (inc_hour) begin
      {edt_h_dez, edt_h_uni} <= bcd_inc_hour(edt_h_dez, edt_h_uni);
    end else if (inc_min) begin
      {edt_m_dez, edt_m_uni} <= bcd_inc_min(edt_m_dez, edt_m_uni);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              tout_cnt <= '0;
    else if (entering | any_edge | ~edit_state) tout_cnt <= '0;
    else                                     tout_cnt <= tout_cnt + TW'(1);
  end

  // Restarting in the "on" phase makes a freshly changed value visible at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (entering | inc_hour | inc_min | ~edit_state) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign edit_active = (state != IDLE);
  assign blank_h     = (state == EDIT_H) & blink_off;
  assign blank_m     = (state == EDIT_M) & blink_off;
  assign load        = (state == COMMIT);

endmodule
